pipe_trace_buffer: RTL and testbench

//  Synthesizable pipeline event recorder that replaces simulation-only $display tracing of the MIPS core.

---
 rtl/pipe_trace_buffer_pkg.sv | 21 ++
 rtl/pipe_trace_buffer_fifo.sv | 62 ++++++
 rtl/pipe_trace_buffer.sv | 137 +++++++++++++
 tb/tb_pipe_trace_buffer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_trace_buffer_pkg.sv
// Shared definitions for the pipeline trace recorder: channel bit indices,
// capture FSM states and the packed record width.
package pipe_trace_pkg;

    localparam int KIND_WB = 0;
    localparam int KIND_MR = 1;
    localparam int KIND_MW = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    // Record layout, MSB first: {ts, pc, kind, wb_reg, wb_data, mem_addr, mem_data}
    function automatic int rec_width(input int ts_w, input int addr_w,
                                     input int reg_w, input int data_w);
        return ts_w + addr_w + 3 + reg_w + data_w + addr_w + data_w;
    endfunction

endpackage

// File: rtl/pipe_trace_buffer_fifo.sv
// Show-ahead FIFO with optional overwrite-oldest when full.
// rd_data reads as zero while empty so downstream fields are clean.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     overwrite,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     dropped
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             do_pop;
    logic             do_write;
    logic             rd_adv;
    logic [CNT_W-1:0] count_next;

    assign full    = (count == CNT_W'(DEPTH));
    assign valid   = (count != '0);
    assign rd_data = valid ? mem[rd_ptr] : '0;

    // Push/pop resolution: a pop frees a slot for a same-cycle push, and an
    // overwrite on full advances the head so the write reuses the oldest slot.
    always_comb begin
        do_pop     = pop & valid;
        dropped    = push & full & ~do_pop;
        do_write   = push & (~full | do_pop | overwrite);
        rd_adv     = do_pop | (dropped & overwrite);
        count_next = count + CNT_W'(do_write) - CNT_W'(rd_adv);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (rd_adv)   rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Storage array, no reset needed since reads are gated by valid
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pipe_trace_buffer.sv
// Pipeline event recorder: filters writeback/memory strobes, timestamps
// qualifying cycles and buffers them for a valid/ready consumer.
module pipe_trace_buffer
    import pipe_trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arm,
    input  logic [2:0]             cfg_en_mask,
    input  logic [REG_W-1:0]       cfg_reg_lo,
    input  logic [REG_W-1:0]       cfg_reg_hi,
    input  logic                   cfg_wrap,
    input  logic                   cfg_trig_en,
    input  logic [ADDR_W-1:0]      cfg_trig_pc,
    input  logic [ADDR_W-1:0]      pc,
    input  logic                   wb_valid,
    input  logic [REG_W-1:0]       wb_reg,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   mr_valid,
    input  logic [ADDR_W-1:0]      mr_addr,
    input  logic [DATA_W-1:0]      mr_data,
    input  logic                   mw_valid,
    input  logic [ADDR_W-1:0]      mw_addr,
    input  logic [DATA_W-1:0]      mw_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TS_W-1:0]        out_ts,
    output logic [ADDR_W-1:0]      out_pc,
    output logic [2:0]             out_kind,
    output logic [REG_W-1:0]       out_wb_reg,
    output logic [DATA_W-1:0]      out_wb_data,
    output logic [ADDR_W-1:0]      out_mem_addr,
    output logic [DATA_W-1:0]      out_mem_data,
    output logic [$clog2(DEPTH):0] count,
    output logic [15:0]            drop_cnt,
    output logic [1:0]             state
);
    localparam int REC_W = rec_width(TS_W, ADDR_W, REG_W, DATA_W);

    state_t             st;
    state_t             st_next;
    logic [TS_W-1:0]    ts;
    logic [2:0]         kind;
    logic               capture_en;
    logic               push;
    logic               dropped;
    logic [REG_W-1:0]   rec_wb_reg;
    logic [DATA_W-1:0]  rec_wb_data;
    logic [ADDR_W-1:0]  rec_mem_addr;
    logic [DATA_W-1:0]  rec_mem_data;
    logic [REC_W-1:0]   rec_in;
    logic [REC_W-1:0]   rec_out;

    // Channel filters and record field selection (mw has priority on mem fields)
    always_comb begin
        kind          = '0;
        kind[KIND_WB] = cfg_en_mask[KIND_WB] & wb_valid & (wb_reg != '0)
                        & (wb_reg >= cfg_reg_lo) & (wb_reg <= cfg_reg_hi);
        kind[KIND_MR] = cfg_en_mask[KIND_MR] & mr_valid;
        kind[KIND_MW] = cfg_en_mask[KIND_MW] & mw_valid;
        rec_wb_reg    = kind[KIND_WB] ? wb_reg  : '0;
        rec_wb_data   = kind[KIND_WB] ? wb_data : '0;
        if (kind[KIND_MW]) begin
            rec_mem_addr = mw_addr;
            rec_mem_data = mw_data;
        end else if (kind[KIND_MR]) begin
            rec_mem_addr = mr_addr;
            rec_mem_data = mr_data;
        end else begin
            rec_mem_addr = '0;
            rec_mem_data = '0;
        end
    end

    // The trigger cycle itself is captured, not only the cycles after it
    assign capture_en = (st == ST_CAPTURE)
                      | ((st == ST_ARMED) & arm & (pc == cfg_trig_pc));
    assign push   = capture_en & (kind != '0);
    assign rec_in = {ts, pc, kind, rec_wb_reg, rec_wb_data, rec_mem_addr, rec_mem_data};

    // Capture FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) st <= ST_IDLE;
        else        st <= st_next;
    end

    // Capture FSM next-state logic; dropping arm returns to IDLE from anywhere
    always_comb begin
        st_next = st;
        if (!arm) begin
            st_next = ST_IDLE;
        end else begin
            case (st)
                ST_IDLE:  st_next = cfg_trig_en ? ST_ARMED : ST_CAPTURE;
                ST_ARMED: if (pc == cfg_trig_pc) st_next = ST_CAPTURE;
                default:  st_next = st;
            endcase
        end
    end

    // Free-running timestamp and saturating lost-record counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts       <= '0;
            drop_cnt <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (dropped && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (out_ready),
        .overwrite (cfg_wrap),
        .wr_data   (rec_in),
        .rd_data   (rec_out),
        .valid     (out_valid),
        .count     (count),
        .dropped   (dropped)
    );

    assign {out_ts, out_pc, out_kind, out_wb_reg, out_wb_data, out_mem_addr, out_mem_data} = rec_out;
    assign state = st;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Self-checking bench for pipe_trace_buffer: vector table for the filter
// rules, directed sequences for full/wrap/trigger/reset corner cases,
// and a scoreboard queue checked whenever the consumer accepts a record.
module tb_pipe_trace_buffer;

    typedef struct packed {
        logic [15:0] ts;
        logic [31:0] pc;
        logic [2:0]  kind;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
        logic [31:0] maddr;
        logic [31:0] mdata;
    } rec_t;

    typedef struct {
        logic [2:0]  mask;
        logic [4:0]  lo, hi;
        logic [31:0] pc;
        logic        wbv;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
        logic        mrv;
        logic [31:0] mraddr, mrdata;
        logic        mwv;
        logic [31:0] mwaddr, mwdata;
        logic [2:0]  ekind;
        logic [4:0]  ewbreg;
        logic [31:0] ewbdata, emaddr, emdata;
    } vec_t;

    logic        clk = 0;
    logic        rst_n;
    logic        arm;
    logic [2:0]  cfg_en_mask;
    logic [4:0]  cfg_reg_lo, cfg_reg_hi;
    logic        cfg_wrap, cfg_trig_en;
    logic [31:0] cfg_trig_pc, pc;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        mr_valid;
    logic [31:0] mr_addr, mr_data;
    logic        mw_valid;
    logic [31:0] mw_addr, mw_data;
    logic        out_valid, out_ready;
    logic [15:0] out_ts;
    logic [31:0] out_pc;
    logic [2:0]  out_kind;
    logic [4:0]  out_wb_reg;
    logic [31:0] out_wb_data, out_mem_addr, out_mem_data;
    logic [4:0]  count;
    logic [15:0] drop_cnt;
    logic [1:0]  state;

    int   tests = 0;
    int   fails = 0;
    bit   sb_on = 1;
    rec_t q[$];
    logic [15:0] model_ts = '0;
    vec_t vecs[13];
    logic [15:0] ev_ts[20];

    pipe_trace_buffer #(
        .DATA_W (32), .ADDR_W (32), .REG_W (5), .DEPTH (16), .TS_W (16)
    ) dut (
        .clk (clk), .rst_n (rst_n), .arm (arm),
        .cfg_en_mask (cfg_en_mask), .cfg_reg_lo (cfg_reg_lo), .cfg_reg_hi (cfg_reg_hi),
        .cfg_wrap (cfg_wrap), .cfg_trig_en (cfg_trig_en), .cfg_trig_pc (cfg_trig_pc),
        .pc (pc), .wb_valid (wb_valid), .wb_reg (wb_reg), .wb_data (wb_data),
        .mr_valid (mr_valid), .mr_addr (mr_addr), .mr_data (mr_data),
        .mw_valid (mw_valid), .mw_addr (mw_addr), .mw_data (mw_data),
        .out_valid (out_valid), .out_ready (out_ready), .out_ts (out_ts), .out_pc (out_pc),
        .out_kind (out_kind), .out_wb_reg (out_wb_reg), .out_wb_data (out_wb_data),
        .out_mem_addr (out_mem_addr), .out_mem_data (out_mem_data),
        .count (count), .drop_cnt (drop_cnt), .state (state)
    );

    always #5 clk = ~clk;

    // Reference timestamp: value during the current cycle is what a record sampled now carries
    always @(posedge clk) model_ts <= rst_n ? model_ts + 16'd1 : 16'd0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: a pop happens at the next edge whenever valid&ready hold at the negedge
    always @(negedge clk) begin
        if (sb_on && rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got ts=%0h pc=%0h, none expected", out_ts, out_pc);
            end else begin
                rec_t e, a;
                e = q.pop_front();
                a = {out_ts, out_pc, out_kind, out_wb_reg, out_wb_data, out_mem_addr, out_mem_data};
                check("sb_rec", 160'(a), 160'(e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        wb_valid = 0; wb_reg = '0; wb_data = '0;
        mr_valid = 0; mr_addr = '0; mr_data = '0;
        mw_valid = 0; mw_addr = '0; mw_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 0; arm = 0; out_ready = 0;
        cfg_en_mask = 3'b111; cfg_reg_lo = 5'd8; cfg_reg_hi = 5'd23;
        cfg_wrap = 0; cfg_trig_en = 0; cfg_trig_pc = '0; pc = '0;
        clear_events();
        step();
        rst_n = 1;
        q.delete();
    endtask

    task automatic mr_hit(input logic [31:0] p, input logic [31:0] a, input logic [31:0] d);
        clear_events();
        pc = p; mr_valid = 1; mr_addr = a; mr_data = d;
    endtask

    task automatic push_mr_exp(input logic [15:0] t, input logic [31:0] p,
                               input logic [31:0] a, input logic [31:0] d);
        q.push_back('{ts: t, pc: p, kind: 3'b010, wbreg: '0, wbdata: '0, maddr: a, mdata: d});
    endtask

    task automatic drain(input string name);
        out_ready = 1;
        clear_events();
        for (int i = 0; i < 40; i++) begin
            if (count == 0 && q.size() == 0) break;
            step();
        end
        check({name, "_drained_q"}, 160'(q.size()), 160'(0));
        check({name, "_drained_cnt"}, 160'(count), 160'(0));
    endtask

    // Fill the FIFO with 20 mr hits while stalled; returns with queue loaded per policy
    task automatic fill20(input bit wrap);
        do_reset();
        cfg_wrap = wrap; arm = 1;
        step();
        for (int i = 0; i < 20; i++) begin
            mr_hit(32'h100 + 32'(i) * 4, 32'h800 + 32'(i), 32'hA000 + 32'(i));
            ev_ts[i] = model_ts;
            step();
        end
        clear_events();
    endtask

    initial begin
        // mask lo hi pc | wb v/reg/data | mr v/addr/data | mw v/addr/data | exp kind/wbreg/wbdata/maddr/mdata
        vecs[0]  = '{3'b111, 5'd8, 5'd23, 32'h1000, 1, 5'd9,  32'h5,    0, 32'h0,   32'h0,    0, 32'h0,   32'h0,  3'b001, 5'd9,  32'h5,    32'h0,   32'h0};
        vecs[1]  = '{3'b111, 5'd8, 5'd23, 32'h1004, 1, 5'd3,  32'h1,    0, 32'h0,   32'h0,    1, 32'h40,  32'h7,  3'b100, 5'd0,  32'h0,    32'h40,  32'h7};
        vecs[2]  = '{3'b111, 5'd8, 5'd23, 32'h1008, 1, 5'd23, 32'hAA,   0, 32'h0,   32'h0,    0, 32'h0,   32'h0,  3'b001, 5'd23, 32'hAA,   32'h0,   32'h0};
        vecs[3]  = '{3'b111, 5'd8, 5'd23, 32'h100C, 1, 5'd8,  32'hBB,   0, 32'h0,   32'h0,    0, 32'h0,   32'h0,  3'b001, 5'd8,  32'hBB,   32'h0,   32'h0};
        vecs[4]  = '{3'b111, 5'd8, 5'd23, 32'h1010, 1, 5'd24, 32'hCC,   0, 32'h0,   32'h0,    0, 32'h0,   32'h0,  3'b000, 5'd0,  32'h0,    32'h0,   32'h0};
        vecs[5]  = '{3'b111, 5'd0, 5'd31, 32'h1014, 1, 5'd0,  32'hDD,   0, 32'h0,   32'h0,    0, 32'h0,   32'h0,  3'b000, 5'd0,  32'h0,    32'h0,   32'h0};
        vecs[6]  = '{3'b111, 5'd20,5'd10, 32'h1018, 1, 5'd15, 32'hEE,   0, 32'h0,   32'h0,    0, 32'h0,   32'h0,  3'b000, 5'd0,  32'h0,    32'h0,   32'h0};
        vecs[7]  = '{3'b111, 5'd8, 5'd23, 32'h101C, 0, 5'd0,  32'h0,    1, 32'h100, 32'h1234, 0, 32'h0,   32'h0,  3'b010, 5'd0,  32'h0,    32'h100, 32'h1234};
        vecs[8]  = '{3'b111, 5'd8, 5'd23, 32'h1020, 0, 5'd0,  32'h0,    1, 32'h300, 32'h66,   1, 32'h200, 32'h55, 3'b110, 5'd0,  32'h0,    32'h200, 32'h55};
        vecs[9]  = '{3'b011, 5'd8, 5'd23, 32'h1024, 1, 5'd10, 32'h77,   1, 32'h300, 32'h66,   1, 32'h200, 32'h55, 3'b011, 5'd10, 32'h77,   32'h300, 32'h66};
        vecs[10] = '{3'b000, 5'd8, 5'd23, 32'h1028, 1, 5'd10, 32'h77,   1, 32'h300, 32'h66,   1, 32'h200, 32'h55, 3'b000, 5'd0,  32'h0,    32'h0,   32'h0};
        vecs[11] = '{3'b001, 5'd0, 5'd31, 32'h102C, 1, 5'd31, 32'hDEAD, 1, 32'h300, 32'h66,   0, 32'h0,   32'h0,  3'b001, 5'd31, 32'hDEAD, 32'h0,   32'h0};
        vecs[12] = '{3'b100, 5'd8, 5'd23, 32'h1030, 1, 5'd12, 32'h99,   0, 32'h0,   32'h0,    1, 32'h44,  32'h88, 3'b100, 5'd0,  32'h0,    32'h44,  32'h88};

        // Reset state
        do_reset();
        check("rst_valid", 160'(out_valid), 160'(0));
        check("rst_count", 160'(count), 160'(0));
        check("rst_drop", 160'(drop_cnt), 160'(0));
        check("rst_state", 160'(state), 160'(0));
        check("rst_data", 160'({out_ts, out_pc, out_kind, out_wb_reg, out_wb_data, out_mem_addr, out_mem_data}), 160'(0));

        // Filter table in CAPTURE with a consumer that is always ready
        arm = 1; out_ready = 1;
        step();
        check("arm_state", 160'(state), 160'(2));
        for (int i = 0; i < 13; i++) begin
            cfg_en_mask = vecs[i].mask; cfg_reg_lo = vecs[i].lo; cfg_reg_hi = vecs[i].hi;
            pc = vecs[i].pc;
            wb_valid = vecs[i].wbv; wb_reg = vecs[i].wbreg; wb_data = vecs[i].wbdata;
            mr_valid = vecs[i].mrv; mr_addr = vecs[i].mraddr; mr_data = vecs[i].mrdata;
            mw_valid = vecs[i].mwv; mw_addr = vecs[i].mwaddr; mw_data = vecs[i].mwdata;
            if (vecs[i].ekind != 0)
                q.push_back('{ts: model_ts, pc: vecs[i].pc, kind: vecs[i].ekind, wbreg: vecs[i].ewbreg,
                              wbdata: vecs[i].ewbdata, maddr: vecs[i].emaddr, mdata: vecs[i].emdata});
            step();
            check($sformatf("vec%0d_count", i), 160'(count), 160'(vecs[i].ekind != 0));
            if (vecs[i].ekind != 0) check($sformatf("vec%0d_kind", i), 160'(out_kind), 160'(vecs[i].ekind));
            else                    check($sformatf("vec%0d_valid", i), 160'(out_valid), 160'(0));
        end
        cfg_en_mask = 3'b111; cfg_reg_lo = 5'd8; cfg_reg_hi = 5'd23;
        drain("table");

        // Full, drop newest: first 16 survive
        fill20(0);
        check("nowrap_count", 160'(count), 160'(16));
        check("nowrap_drop", 160'(drop_cnt), 160'(4));
        check("nowrap_head_ts", 160'(out_ts), 160'(ev_ts[0]));
        step();
        check("nowrap_hold_ts", 160'(out_ts), 160'(ev_ts[0]));
        for (int i = 0; i < 16; i++) push_mr_exp(ev_ts[i], 32'h100 + 32'(i) * 4, 32'h800 + 32'(i), 32'hA000 + 32'(i));
        drain("nowrap");

        // Full, overwrite oldest: last 16 survive
        fill20(1);
        check("wrap_count", 160'(count), 160'(16));
        check("wrap_drop", 160'(drop_cnt), 160'(4));
        check("wrap_head_ts", 160'(out_ts), 160'(ev_ts[4]));
        for (int i = 4; i < 20; i++) push_mr_exp(ev_ts[i], 32'h100 + 32'(i) * 4, 32'h800 + 32'(i), 32'hA000 + 32'(i));
        drain("wrap");

        // PC trigger: only the trigger cycle and later are captured
        do_reset();
        cfg_trig_en = 1; cfg_trig_pc = 32'h20; arm = 1; out_ready = 1;
        step();
        check("trig_armed", 160'(state), 160'(1));
        mr_hit(32'h10, 32'h500, 32'h1);
        step();
        mr_hit(32'h1C, 32'h504, 32'h2);
        step();
        check("trig_still_armed", 160'(state), 160'(1));
        check("trig_none_yet", 160'(count), 160'(0));
        mr_hit(32'h20, 32'h508, 32'h3);
        push_mr_exp(model_ts, 32'h20, 32'h508, 32'h3);
        step();
        check("trig_capture", 160'(state), 160'(2));
        mr_hit(32'h24, 32'h50C, 32'h4);
        push_mr_exp(model_ts, 32'h24, 32'h50C, 32'h4);
        step();
        drain("trig");

        // Full with simultaneous push and pop, then reset mid-drain
        do_reset();
        arm = 1;
        step();
        for (int i = 0; i < 16; i++) begin
            mr_hit(32'h200 + 32'(i), 32'h900 + 32'(i), 32'hB000 + 32'(i));
            push_mr_exp(model_ts, 32'h200 + 32'(i), 32'h900 + 32'(i), 32'hB000 + 32'(i));
            step();
        end
        check("full_count", 160'(count), 160'(16));
        check("full_drop", 160'(drop_cnt), 160'(0));
        mr_hit(32'h300, 32'hC00, 32'hC0DE);
        push_mr_exp(model_ts, 32'h300, 32'hC00, 32'hC0DE);
        out_ready = 1;
        step();
        check("pushpop_count", 160'(count), 160'(16));
        check("pushpop_drop", 160'(drop_cnt), 160'(0));
        clear_events();
        step();
        step();
        check("middrain_count", 160'(count), 160'(14));
        rst_n = 0;
        step();
        check("rstmid_valid", 160'(out_valid), 160'(0));
        check("rstmid_count", 160'(count), 160'(0));
        check("rstmid_state", 160'(state), 160'(0));
        check("rstmid_kind", 160'(out_kind), 160'(0));
        rst_n = 1;
        q.delete();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
